// File: rtl/l2_port_arbiter_if.sv
// Bundles the I-cache, D-cache and L2 sides of the shared L2 port.
// The arbiter connects through the slave modport; the L1/L2 environment uses master.
interface l2_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BE_W   = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [BE_W-1:0]   d_byte_enable;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [BE_W-1:0]   l2_byte_enable;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;

    logic              busy;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable,
               l2_rdata, l2_resp,
        output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address,
               l2_wdata, l2_byte_enable, busy
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, d_byte_enable,
               l2_rdata, l2_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_address,
               l2_wdata, l2_byte_enable, busy
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one line-granular L2 port between the L1 I-cache and D-cache.
// One transaction in flight; the granted request is latched and held on L2 until l2_resp.
module l2_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int BE_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    l2_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              last_d_r;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              d_pend_s;
    logic              rd_r;
    logic              wr_r;
    logic              rd_next_s;
    logic              wr_next_s;
    logic [ADDR_W-1:0] addr_r;
    logic [LINE_W-1:0] wdata_r;
    logic [BE_W-1:0]   be_r;

    assign d_pend_s = bus.d_read | bus.d_write;

    // Next-state, grant decision and next strobe values.
    always_comb begin
        state_next_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        rd_next_s    = rd_r;
        wr_next_s    = wr_r;
        case (state_r)
            IDLE: begin
                rd_next_s = 1'b0;
                wr_next_s = 1'b0;
                if (bus.i_read && d_pend_s) begin
                    // Contest: the side that did not win last time takes it.
                    if (last_d_r) begin
                        grant_i_s = 1'b1;
                    end else begin
                        grant_d_s = 1'b1;
                    end
                end else if (bus.i_read) begin
                    grant_i_s = 1'b1;
                end else if (d_pend_s) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                    grant_d_s = 1'b0;
                end
                if (grant_i_s) begin
                    state_next_s = SERVE_I;
                    rd_next_s    = 1'b1;
                end else if (grant_d_s) begin
                    // Read and write together is treated as a write.
                    state_next_s = SERVE_D;
                    wr_next_s    = bus.d_write;
                    rd_next_s    = ~bus.d_write;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.l2_resp) begin
                    state_next_s = DONE;
                    rd_next_s    = 1'b0;
                    wr_next_s    = 1'b0;
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                rd_next_s    = 1'b0;
                wr_next_s    = 1'b0;
            end
            default: begin
                state_next_s = IDLE;
                rd_next_s    = 1'b0;
                wr_next_s    = 1'b0;
            end
        endcase
    end

    // State, round-robin history, registered strobes and the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {LINE_W{1'b0}};
            be_r     <= {BE_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            rd_r    <= rd_next_s;
            wr_r    <= wr_next_s;
            if (grant_i_s) begin
                last_d_r <= 1'b0;
                addr_r   <= bus.i_address;
                wdata_r  <= {LINE_W{1'b0}};
                be_r     <= {BE_W{1'b1}};
            end else if (grant_d_s) begin
                last_d_r <= 1'b1;
                addr_r   <= bus.d_address;
                wdata_r  <= bus.d_wdata;
                be_r     <= bus.d_write ? bus.d_byte_enable : {BE_W{1'b1}};
            end
        end
    end

    assign bus.l2_read        = rd_r;
    assign bus.l2_write       = wr_r;
    assign bus.l2_address     = addr_r;
    assign bus.l2_wdata       = wdata_r;
    assign bus.l2_byte_enable = be_r;
    assign bus.busy           = (state_r != IDLE);

    // Completion is forwarded in the same cycle as l2_resp, only to the served side.
    assign bus.i_resp  = (state_r == SERVE_I) & bus.l2_resp;
    assign bus.d_resp  = (state_r == SERVE_D) & bus.l2_resp;
    assign bus.i_rdata = bus.l2_rdata;
    assign bus.d_rdata = bus.l2_rdata;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized bench for l2_port_arbiter: acts as both L1 caches and as L2, and predicts
// grants, latched L2 request contents and completions from a transaction-level model.
module tb_l2_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int BE_W   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BE_W(BE_W)) bus ();

    l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BE_W(BE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of the two requesters and the arbitration history
    bit                pend_i, pend_d, last_d;
    logic [ADDR_W-1:0] ia, da;
    logic [LINE_W-1:0] dw;
    logic [BE_W-1:0]   dbe;
    bit                drd, dwr;

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_i(input logic [ADDR_W-1:0] a);
        pend_i        = 1'b1;
        ia            = a;
        bus.i_read    = 1'b1;
        bus.i_address = ia;
    endtask

    task automatic drive_d();
        pend_d            = 1'b1;
        bus.d_read        = drd;
        bus.d_write       = dwr;
        bus.d_address     = da;
        bus.d_wdata       = dw;
        bus.d_byte_enable = dbe;
    endtask

    task automatic new_d_rand();
        int op;
        op  = $urandom_range(0, 2);
        drd = (op != 1);
        dwr = (op != 0);
        da  = $urandom & 32'hFFFF_FFE0;
        dw  = rand_line();
        dbe = $urandom;
        drive_d();
    endtask

    // One complete transaction starting in an IDLE cycle (called at posedge+1).
    task automatic round(input bit allow_new, input bit force_both);
        bit                win_d;
        bit                erd, ewr;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ew, line;
        logic [BE_W-1:0]   ebe;
        int                lat;
        if (allow_new) begin
            if (!pend_i && (force_both || $urandom_range(0, 3) != 0)) new_i($urandom & 32'hFFFF_FFE0);
            if (!pend_d && (force_both || $urandom_range(0, 3) != 0)) new_d_rand();
            if (!pend_i && !pend_d) begin
                if ($urandom_range(0, 1) == 0) new_i($urandom & 32'hFFFF_FFE0);
                else new_d_rand();
            end
        end
        if (!pend_i && !pend_d) return;
        win_d = pend_d && (!pend_i || !last_d);
        if (win_d) begin
            ea = da; ew = dw; ewr = dwr; erd = !dwr;
            ebe = dwr ? dbe : {BE_W{1'b1}};
        end else begin
            ea = ia; ew = '0; ebe = {BE_W{1'b1}}; ewr = 1'b0; erd = 1'b1;
        end
        // A stray l2_resp in IDLE must not complete anything
        bus.l2_resp  = ($urandom_range(0, 3) == 0);
        bus.l2_rdata = rand_line();
        @(negedge clk);
        check_eq("idle_busy", bus.busy, 1'b0);
        check_eq("idle_rd", bus.l2_read, 1'b0);
        check_eq("idle_wr", bus.l2_write, 1'b0);
        check_eq("idle_iresp", bus.i_resp, 1'b0);
        check_eq("idle_dresp", bus.d_resp, 1'b0);
        last_d = win_d;
        tick();
        bus.l2_resp = 1'b0;
        // Granted requester wiggles its inputs; the latched copy must stay on L2
        if ($urandom_range(0, 1) == 1) begin
            if (win_d) begin
                bus.d_address     = $urandom;
                bus.d_wdata       = rand_line();
                bus.d_byte_enable = $urandom;
            end else begin
                bus.i_address = $urandom;
            end
        end
        lat = $urandom_range(0, 4);
        for (int k = 0; k <= lat; k++) begin
            if (k == lat) begin
                line         = rand_line();
                bus.l2_resp  = 1'b1;
                bus.l2_rdata = line;
                if (!win_d && !pend_d && $urandom_range(0, 1) == 1) new_d_rand();
                if (win_d && !pend_i && $urandom_range(0, 1) == 1) new_i($urandom & 32'hFFFF_FFE0);
            end
            @(negedge clk);
            check_eq("serve_rd", bus.l2_read, erd);
            check_eq("serve_wr", bus.l2_write, ewr);
            check_eq("serve_addr", bus.l2_address, ea);
            check_eq("serve_busy", bus.busy, 1'b1);
            if (ewr || !win_d) begin
                check_eq("serve_be", bus.l2_byte_enable, ebe);
                check_eq("serve_wdata", bus.l2_wdata, ew);
            end
            if (k == lat) begin
                check_eq("win_resp", win_d ? bus.d_resp : bus.i_resp, 1'b1);
                check_eq("lose_resp", win_d ? bus.i_resp : bus.d_resp, 1'b0);
                check_eq("win_rdata", win_d ? bus.d_rdata : bus.i_rdata, line);
            end else begin
                check_eq("wait_iresp", bus.i_resp, 1'b0);
                check_eq("wait_dresp", bus.d_resp, 1'b0);
            end
            tick();
        end
        bus.l2_resp = 1'b0;
        if (win_d) begin
            pend_d = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        end else begin
            pend_i = 1'b0; bus.i_read = 1'b0;
        end
        @(negedge clk);
        check_eq("done_busy", bus.busy, 1'b1);
        check_eq("done_rd", bus.l2_read, 1'b0);
        check_eq("done_wr", bus.l2_write, 1'b0);
        check_eq("done_iresp", bus.i_resp, 1'b0);
        check_eq("done_dresp", bus.d_resp, 1'b0);
        tick();
    endtask

    task automatic check_reset_state();
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_rd", bus.l2_read, 1'b0);
        check_eq("rst_wr", bus.l2_write, 1'b0);
        check_eq("rst_iresp", bus.i_resp, 1'b0);
        check_eq("rst_dresp", bus.d_resp, 1'b0);
        check_eq("rst_addr", bus.l2_address, '0);
        check_eq("rst_wdata", bus.l2_wdata, '0);
        check_eq("rst_be", bus.l2_byte_enable, '0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0;
        bus.d_wdata = '0; bus.d_byte_enable = '0;
        bus.l2_rdata = '0; bus.l2_resp = 1'b0;
        pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;
        tick();

        // Directed D write with a half mask, then a lone I read
        drd = 1'b0; dwr = 1'b1; da = 32'h8000_0020; dbe = 32'h0000_FFFF; dw = rand_line();
        drive_d();
        round(1'b0, 1'b0);
        new_i(32'h0000_1000);
        round(1'b0, 1'b0);

        round(1'b1, 1'b1);
        repeat (40) round(1'b1, 1'b0);
        repeat (3) round(1'b0, 1'b0);

        // Reset while serving an I read abandons it
        new_i(32'h0000_2000);
        @(negedge clk);
        check_eq("pre_busy", bus.busy, 1'b0);
        tick();
        @(negedge clk);
        check_eq("svi_rd", bus.l2_read, 1'b1);
        check_eq("svi_addr", bus.l2_address, ia);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("svi_iresp", bus.i_resp, 1'b0);
        tick();
        rst = 1'b0;
        bus.i_read = 1'b0; pend_i = 1'b0; last_d = 1'b0;
        bus.l2_resp = 1'b1;
        @(negedge clk);
        check_reset_state();
        tick();
        bus.l2_resp = 1'b0;

        // After reset D must win the first contest again
        round(1'b1, 1'b1);
        repeat (40) round(1'b1, 1'b0);
        repeat (3) round(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
